// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg
//   Shared constants for the boot-ROM arbiter:
//     - FSM state encodings ST_IDLE / ST_REQ / ST_WAIT
//     - owner encodings ARB_M0 (CPU fetch) / ARB_M1 (loader/debug)
//     - pick_owner(): round-robin selection between the two masters
package rom_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    // A lone requester always wins; on a tie the round-robin pointer decides.
    function automatic logic pick_owner(input logic m0_want,
                                        input logic m1_want,
                                        input logic rr_ptr);
        if (m0_want && m1_want) begin
            return rr_ptr;
        end else if (m1_want) begin
            return ARB_M1;
        end else begin
            return ARB_M0;
        end
    endfunction

endpackage

// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Shares the single-port boot ROM between two read masters (M0 = CPU
//   instruction fetch, M1 = loader/debug port). Round-robin arbitration,
//   one outstanding ROM access at a time, all handshakes active-low.
//
//   Optional feature macro: ROM_ARB_BURST_EN
//     When defined, an owner still holding its request at completion is
//     re-granted straight away (REQ again) up to MAX_BURST back-to-back
//     accesses before the other master gets a turn.
//
//   Handshake: a master drives req_ low with a stable address and holds it
//   until it sees its own rdy_ low for one cycle; rd_data is valid only in
//   that cycle. Dropping req_ early does not cancel an access in flight.
//
//   Ports
//     clk, reset         clock, synchronous active-low reset
//     m0_req_/m0_addr    M0 request and address;  m0_rdy_ M0 read done
//     m1_req_/m1_addr    M1 request and address;  m1_rdy_ M1 read done
//     rd_data            read data to both masters
//     rom_cs_/rom_as_    ROM chip select / address strobe (one-cycle pulse)
//     rom_addr           latched ROM address
//     rom_rd_data        ROM read data;  rom_rdy_ ROM ready (cycle after strobe)
//     dbg_state          current FSM state (ST_* encoding)
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
`ifdef ROM_ARB_BURST_EN
    ,
    parameter int MAX_BURST = 4
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req_,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_rdy_,
    input  logic              m1_req_,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_rdy_,
    output logic [DATA_W-1:0] rd_data,
    output logic              rom_cs_,
    output logic              rom_as_,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rd_data,
    input  logic              rom_rdy_,
    output logic [1:0]        dbg_state
);

    logic [1:0] state;
    logic       owner;
    logic       rr_ptr;

    logic       any_req;
    logic       grant;
    logic       done;

    assign any_req = ~m0_req_ | ~m1_req_;
    assign grant   = pick_owner(~m0_req_, ~m1_req_, rr_ptr);
    assign done    = (state == ST_WAIT) && ~rom_rdy_;

`ifdef ROM_ARB_BURST_EN
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    logic [BW-1:0]     burst_cnt;
    logic              owner_req;
    logic [ADDR_W-1:0] owner_addr;

    assign owner_req  = (owner == ARB_M0) ? ~m0_req_ : ~m1_req_;
    assign owner_addr = (owner == ARB_M0) ? m0_addr : m1_addr;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            owner    <= ARB_M0;
            rr_ptr   <= ARB_M0;
            rom_addr <= '0;
`ifdef ROM_ARB_BURST_EN
            burst_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner    <= grant;
                        rom_addr <= (grant == ARB_M0) ? m0_addr : m1_addr;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
`ifdef ROM_ARB_BURST_EN
                        if (owner_req && (burst_cnt < BURST_LAST)) begin
                            rom_addr  <= owner_addr;
                            burst_cnt <= burst_cnt + BW'(1);
                            state     <= ST_REQ;
                        end else begin
                            burst_cnt <= '0;
                            rr_ptr    <= ~owner;
                            state     <= ST_IDLE;
                        end
`else
                        rr_ptr <= ~owner;
                        state  <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes and rdy_ are gated by reset so a response landing in the same
    // cycle reset is asserted is dropped rather than reported.
    assign rom_cs_   = ~((state == ST_REQ) && reset);
    assign rom_as_   = ~((state == ST_REQ) && reset);
    assign m0_rdy_   = ~(done && reset && (owner == ARB_M0));
    assign m1_rdy_   = ~(done && reset && (owner == ARB_M1));
    assign rd_data   = rom_rd_data;
    assign dbg_state = state;

endmodule
